sram_bus_arbiter: RTL and testbench

SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

---
 rtl/sram_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// SRAM bus arbiter between the Z80 CPU and the CRTC/DMAC.
//
// The DMA side asks for the bus with dma_req. The arbiter forwards this to the
// Z80 as cpu_busreq and waits for cpu_busack. It then grants the SRAM to the
// DMA for at most MAX_BURST cycles. After a truncated burst the CPU keeps the
// bus for HOLDOFF cycles before the DMA may re-request.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   dma_req    in   bus request from CRTC/DMAC
//   dma_adr    in   [15:0] DMA read address
//   cpu_busack in   bus acknowledge from the Z80
//   cpu_adr    in   [15:0] CPU address
//   cpu_mreq   in   CPU memory request
//   cpu_wr     in   CPU write strobe
//   cpu_start  in   CPU machine-cycle start pulse
//   we_ext_ram in   write enable for 0000h-7FFFh
//   cpu_busreq out  bus request to the Z80 (registered)
//   dma_gnt    out  grant to the CRTC/DMAC (registered)
//   ram_adr    out  [15:0] SRAM address (combinational mux)
//   ram_we     out  SRAM write enable (combinational)
//   trunc      out  one-cycle pulse when a burst is truncated (registered)
//   proto_err  out  sticky flag: Z80 dropped busack during a grant (registered)

module sram_bus_arbiter #(
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned HOLDOFF   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_req,
  input  logic [15:0] dma_adr,
  input  logic        cpu_busack,
  input  logic [15:0] cpu_adr,
  input  logic        cpu_mreq,
  input  logic        cpu_wr,
  input  logic        cpu_start,
  input  logic        we_ext_ram,
  output logic        cpu_busreq,
  output logic        dma_gnt,
  output logic [15:0] ram_adr,
  output logic        ram_we,
  output logic        trunc,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StGrant = 2'd2,
    StHold  = 2'd3
  } state_e;

  localparam logic [7:0] BurstLast = 8'(MAX_BURST - 1);
  localparam logic [3:0] HoldLoad  = 4'(HOLDOFF);

  state_e     state_q;
  logic [7:0] burst_cnt_q;
  logic [3:0] hold_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cpu_busreq  <= 1'b0;
      dma_gnt     <= 1'b0;
      trunc       <= 1'b0;
      proto_err   <= 1'b0;
      burst_cnt_q <= 8'd0;
      hold_cnt_q  <= 4'd0;
    end else begin
      trunc <= 1'b0;
      case (state_q)
        StIdle: begin
          cpu_busreq <= 1'b0;
          dma_gnt    <= 1'b0;
          if (dma_req) begin
            state_q    <= StReq;
            cpu_busreq <= 1'b1;
          end
        end

        StReq: begin
          // A withdrawn request wins over a simultaneous acknowledge.
          if (!dma_req) begin
            state_q    <= StIdle;
            cpu_busreq <= 1'b0;
          end else if (cpu_busack) begin
            state_q     <= StGrant;
            dma_gnt     <= 1'b1;
            burst_cnt_q <= 8'd0;
          end
        end

        StGrant: begin
          if (!dma_req) begin
            // Normal end of burst; not a truncation even on the last cycle.
            state_q    <= StIdle;
            cpu_busreq <= 1'b0;
            dma_gnt    <= 1'b0;
          end else if (!cpu_busack) begin
            // Z80 took the bus back while we were granted.
            state_q    <= StIdle;
            cpu_busreq <= 1'b0;
            dma_gnt    <= 1'b0;
            proto_err  <= 1'b1;
          end else if (burst_cnt_q == BurstLast) begin
            state_q    <= StHold;
            cpu_busreq <= 1'b0;
            dma_gnt    <= 1'b0;
            trunc      <= 1'b1;
            hold_cnt_q <= HoldLoad;
          end else begin
            burst_cnt_q <= burst_cnt_q + 8'd1;
          end
        end

        StHold: begin
          cpu_busreq <= 1'b0;
          dma_gnt    <= 1'b0;
          if (hold_cnt_q <= 4'd1) begin
            state_q    <= StIdle;
            hold_cnt_q <= 4'd0;
          end else begin
            hold_cnt_q <= hold_cnt_q - 4'd1;
          end
        end

        default: begin
          state_q    <= StIdle;
          cpu_busreq <= 1'b0;
          dma_gnt    <= 1'b0;
        end
      endcase
    end
  end

  // The DMA only reads, so CPU writes are blocked while it owns the bus.
  // Writes below 8000h additionally need we_ext_ram.
  always_comb begin
    ram_adr = dma_gnt ? dma_adr : cpu_adr;
    ram_we  = 1'b0;
    if (!dma_gnt) begin
      ram_we = cpu_mreq & cpu_wr & ~cpu_start & (cpu_adr[15] | we_ext_ram);
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dma_req = 1'b0;
  logic [15:0] dma_adr = 16'h0000;
  logic        cpu_busack = 1'b0;
  logic [15:0] cpu_adr = 16'h0000;
  logic        cpu_mreq = 1'b0;
  logic        cpu_wr = 1'b0;
  logic        cpu_start = 1'b0;
  logic        we_ext_ram = 1'b0;
  logic        cpu_busreq;
  logic        dma_gnt;
  logic [15:0] ram_adr;
  logic        ram_we;
  logic        trunc;
  logic        proto_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(
    .MAX_BURST(64),
    .HOLDOFF  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dma_req   (dma_req),
    .dma_adr   (dma_adr),
    .cpu_busack(cpu_busack),
    .cpu_adr   (cpu_adr),
    .cpu_mreq  (cpu_mreq),
    .cpu_wr    (cpu_wr),
    .cpu_start (cpu_start),
    .we_ext_ram(we_ext_ram),
    .cpu_busreq(cpu_busreq),
    .dma_gnt   (dma_gnt),
    .ram_adr   (ram_adr),
    .ram_we    (ram_we),
    .trunc     (trunc),
    .proto_err (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle; inputs set afterwards apply to the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int gnt_cycles;
  int lo_cycles;
  int trunc_seen;
  int gnt_seen;

  initial begin
    cpu_adr = 16'h1234;
    dma_adr = 16'habcd;
    #1;
    // Reset state
    check("rst_busreq", 32'(cpu_busreq), 32'd0);
    check("rst_gnt", 32'(dma_gnt), 32'd0);
    check("rst_trunc", 32'(trunc), 32'd0);
    check("rst_proto", 32'(proto_err), 32'd0);
    check("rst_adr", 32'(ram_adr), 32'h1234);
    tick();
    tick();
    reset = 1'b0;

    // Request, busack 3 cycles after busreq, grant one cycle later
    dma_req = 1'b1;
    tick();
    check("req_busreq", 32'(cpu_busreq), 32'd1);
    check("req_gnt0", 32'(dma_gnt), 32'd0);
    tick();
    tick();
    check("req_wait_gnt", 32'(dma_gnt), 32'd0);
    check("req_wait_busreq", 32'(cpu_busreq), 32'd1);
    cpu_busack = 1'b1;
    tick();
    check("gnt_up", 32'(dma_gnt), 32'd1);
    check("gnt_adr", 32'(ram_adr), 32'habcd);

    // Held request: 64 granted cycles, trunc pulse, holdoff gap
    gnt_cycles = 1;
    trunc_seen = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (trunc) trunc_seen++;
      if (dma_gnt) gnt_cycles++;
      else break;
    end
    check("burst_len", 32'(gnt_cycles), 32'd64);
    check("trunc_pulse", 32'(trunc), 32'd1);
    check("hold_busreq", 32'(cpu_busreq), 32'd0);
    lo_cycles = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (trunc) trunc_seen++;
      if (!cpu_busreq) lo_cycles++;
      else break;
    end
    // 4 HOLD cycles plus the IDLE cycle that samples dma_req again
    check("holdoff_gap", 32'(lo_cycles), 32'd5);
    check("trunc_once", 32'(trunc_seen), 32'd1);
    check("rereq_busreq", 32'(cpu_busreq), 32'd1);
    tick();
    check("regnt", 32'(dma_gnt), 32'd1);

    // CPU write attempt while DMA is granted
    cpu_adr  = 16'h8000;
    cpu_mreq = 1'b1;
    cpu_wr   = 1'b1;
    #1;
    check("we_during_gnt", 32'(ram_we), 32'd0);
    check("adr_during_gnt", 32'(ram_adr), 32'habcd);

    // Z80 drops busack mid-grant
    cpu_busack = 1'b0;
    tick();
    check("proto_set", 32'(proto_err), 32'd1);
    check("proto_gnt", 32'(dma_gnt), 32'd0);
    check("proto_busreq", 32'(cpu_busreq), 32'd0);
    check("we_after_gnt", 32'(ram_we), 32'd1);
    tick();
    check("proto_rereq", 32'(cpu_busreq), 32'd1);
    check("proto_sticky", 32'(proto_err), 32'd1);

    // Request withdrawn in REQ before busack
    dma_req = 1'b0;
    tick();
    check("drop_busreq", 32'(cpu_busreq), 32'd0);
    check("drop_trunc", 32'(trunc), 32'd0);
    reset = 1'b1;
    #1;
    check("proto_clr", 32'(proto_err), 32'd0);
    tick();
    reset = 1'b0;

    // Withdrawal has priority over a simultaneous busack
    dma_req = 1'b1;
    tick();
    check("prio_req", 32'(cpu_busreq), 32'd1);
    dma_req    = 1'b0;
    cpu_busack = 1'b1;
    tick();
    check("prio_busreq", 32'(cpu_busreq), 32'd0);
    gnt_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dma_gnt || trunc) gnt_seen++;
    end
    check("prio_no_gnt", 32'(gnt_seen), 32'd0);

    // CPU write decoding with no grant
    cpu_adr    = 16'h4000;
    we_ext_ram = 1'b0;
    cpu_start  = 1'b0;
    #1;
    check("we_4000_noext", 32'(ram_we), 32'd0);
    we_ext_ram = 1'b1;
    #1;
    check("we_4000_ext", 32'(ram_we), 32'd1);
    cpu_adr    = 16'h8000;
    we_ext_ram = 1'b0;
    #1;
    check("we_8000", 32'(ram_we), 32'd1);
    cpu_start = 1'b1;
    #1;
    check("we_8000_start", 32'(ram_we), 32'd0);
    cpu_start = 1'b0;
    cpu_wr    = 1'b0;
    #1;
    check("we_read", 32'(ram_we), 32'd0);

    // dma_req drop on the final burst cycle is not a truncation
    tick();
    dma_req = 1'b1;
    tick();
    tick();
    check("last_gnt", 32'(dma_gnt), 32'd1);
    for (int i = 0; i < 63; i++) tick();
    check("last_still_gnt", 32'(dma_gnt), 32'd1);
    dma_req = 1'b0;
    tick();
    check("last_trunc", 32'(trunc), 32'd0);
    check("last_gnt_off", 32'(dma_gnt), 32'd0);
    check("last_proto", 32'(proto_err), 32'd0);

    // Asynchronous reset mid-grant
    dma_req = 1'b1;
    tick();
    tick();
    check("ar_gnt", 32'(dma_gnt), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_gnt_drop", 32'(dma_gnt), 32'd0);
    check("ar_busreq_drop", 32'(cpu_busreq), 32'd0);
    check("ar_adr", 32'(ram_adr), 32'h8000);
    #1;
    reset = 1'b0;
    dma_req = 1'b0;
    tick();
    check("ar_no_req", 32'(cpu_busreq), 32'd0);
    dma_req = 1'b1;
    tick();
    check("ar_req", 32'(cpu_busreq), 32'd1);
    check("ar_req_gnt", 32'(dma_gnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
